// File: rtl/bus_transfer_sequencer_if.sv
// Command handshake, memory strobe and bus-enable bundle between the control unit
// (master) and the bus transfer sequencer (slave).
interface bus_transfer_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [4:0]  cmd_src;
  logic [4:0]  cmd_dst;
  logic        cmd_wait;
  logic        mem_done;
  logic [23:0] src_oe;
  logic [23:0] dst_we;
  logic        mem_read;
  logic        busy;
  logic        err;
  logic [15:0] xfer_count;

  modport master (
    output cmd_valid, cmd_src, cmd_dst, cmd_wait, mem_done,
    input  cmd_ready, src_oe, dst_we, mem_read, busy, err, xfer_count
  );

  modport slave (
    input  cmd_valid, cmd_src, cmd_dst, cmd_wait, mem_done,
    output cmd_ready, src_oe, dst_we, mem_read, busy, err, xfer_count
  );
endinterface

// File: rtl/bus_transfer_sequencer.sv
// Queues (src, dst, wait) register-transfer commands and issues them one per cycle as one-hot
// bus enables. Define BUS_SEQ_STATS_EN to build the 16-bit completed-transfer counter.
module bus_transfer_sequencer #(
  parameter int FIFO_DEPTH   = 4,
  parameter int WAIT_TIMEOUT = 15
) (
  input logic                     clock,
  input logic                     clear,
  bus_transfer_sequencer_if.slave bus
);
  localparam int PtrW = $clog2(FIFO_DEPTH);
  localparam int CntW = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [4:0] src;
    logic [4:0] dst;
    logic       wait_mem;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_MEM} state_e;

  cmd_t            fifo_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  state_e          state_q, state_d;
  cmd_t            cur_q, cur_d;
  logic [7:0]      wait_q, wait_d;
  logic [23:0]     src_oe_q, src_oe_d, dst_we_q, dst_we_d;
  logic            mem_read_q, mem_read_d;
  logic            err_q, err_d;
  logic            full, empty, pop, accept, illegal, push, timeout;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntW'(FIFO_DEPTH));
  assign pop     = (state_q != WAIT_MEM) && !empty;
  // A pop this cycle frees a slot, so a full queue that is draining still takes a command.
  assign bus.cmd_ready = !full || pop;
  assign accept  = bus.cmd_valid && bus.cmd_ready;
  assign illegal = (bus.cmd_src >= 5'd24) || (bus.cmd_dst >= 5'd24);
  assign push    = accept && !illegal;
  assign timeout = (state_q == WAIT_MEM) && !bus.mem_done && (wait_q == 8'(WAIT_TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= '{src: bus.cmd_src, dst: bus.cmd_dst, wait_mem: bus.cmd_wait};
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + PtrW'(push);
    rd_ptr_d = rd_ptr_q + PtrW'(pop);
    count_d  = count_q + CntW'(push) - CntW'(pop);
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      cur_q      <= '0;
      wait_q     <= '0;
      src_oe_q   <= '0;
      dst_we_q   <= '0;
      mem_read_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      cur_q      <= cur_d;
      wait_q     <= wait_d;
      src_oe_q   <= src_oe_d;
      dst_we_q   <= dst_we_d;
      mem_read_q <= mem_read_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    wait_d  = wait_q;
    unique case (state_q)
      IDLE, ISSUE: begin
        if (pop) begin
          cur_d   = fifo_q[rd_ptr_q];
          wait_d  = '0;
          state_d = fifo_q[rd_ptr_q].wait_mem ? WAIT_MEM : ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_MEM: begin
        if (bus.mem_done) begin
          state_d = ISSUE;
        end else if (timeout) begin
          state_d = IDLE;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they leave the flops aligned with the state.
  always_comb begin
    src_oe_d   = '0;
    dst_we_d   = '0;
    mem_read_d = (state_d == WAIT_MEM);
    err_d      = (accept && illegal) || timeout;
    if (state_d == ISSUE) begin
      src_oe_d = 24'(1) << cur_d.src;
      dst_we_d = 24'(1) << cur_d.dst;
    end
  end

  assign bus.src_oe   = src_oe_q;
  assign bus.dst_we   = dst_we_q;
  assign bus.mem_read = mem_read_q;
  assign bus.err      = err_q;
  assign bus.busy     = !empty || (state_q != IDLE);

`ifdef BUS_SEQ_STATS_EN
  logic [15:0] xfer_q;

  always_ff @(posedge clock) begin
    if (!clear) begin
      xfer_q <= '0;
    end else if (state_q == ISSUE) begin
      xfer_q <= xfer_q + 16'd1;
    end
  end

  assign bus.xfer_count = xfer_q;
`else
  assign bus.xfer_count = 16'd0;
`endif
endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// Directed self-checking bench for bus_transfer_sequencer; xfer_count expectations follow
// whether BUS_SEQ_STATS_EN is defined for the build.
module tb_bus_transfer_sequencer;
  logic clock;
  logic clear;
  int   checks;
  int   errors;
  int   expXfer;

`ifdef BUS_SEQ_STATS_EN
  localparam bit StatsOn = 1'b1;
`else
  localparam bit StatsOn = 1'b0;
`endif

  bus_transfer_sequencer_if bus ();

  bus_transfer_sequencer #(
    .FIFO_DEPTH  (4),
    .WAIT_TIMEOUT(15)
  ) dut (
    .clock(clock),
    .clear(clear),
    .bus  (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [4:0] src, input logic [4:0] dst,
                               input logic waitMem);
    bus.cmd_valid = valid;
    bus.cmd_src   = src;
    bus.cmd_dst   = dst;
    bus.cmd_wait  = waitMem;
  endtask

  task automatic test_reset();
    clear = 1'b0;
    applyStimulus(1'b1, 5'd1, 5'd2, 1'b0);
    tick();
    tick();
    checks++; if (bus.src_oe !== 24'h0) begin errors++; $display("[TB] FAIL reset_src_oe: got %h expected %h", bus.src_oe, 24'h0); end
    checks++; if (bus.dst_we !== 24'h0) begin errors++; $display("[TB] FAIL reset_dst_we: got %h expected %h", bus.dst_we, 24'h0); end
    checks++; if (bus.mem_read !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_read: got %b expected 0", bus.mem_read); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", bus.err); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.xfer_count !== 16'h0) begin errors++; $display("[TB] FAIL reset_xfer_count: got %h expected 0000", bus.xfer_count); end
    clear = 1'b1;
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0);
    tick();
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_cmd_ready: got %b expected 1", bus.cmd_ready); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_nothing_queued: busy got %b expected 0", bus.busy); end
    tick();
    checks++; if (bus.src_oe !== 24'h0) begin errors++; $display("[TB] FAIL reset_no_issue: got %h expected %h", bus.src_oe, 24'h0); end
  endtask

  task automatic test_single();
    applyStimulus(1'b1, 5'd20, 5'd20, 1'b0);
    tick();
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0);
    checks++; if (bus.src_oe !== 24'h0) begin errors++; $display("[TB] FAIL single_early: src_oe got %h expected %h", bus.src_oe, 24'h0); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL single_busy: got %b expected 1", bus.busy); end
    tick();
    checks++; if (bus.src_oe !== 24'h100000) begin errors++; $display("[TB] FAIL single_src_oe: got %h expected %h", bus.src_oe, 24'h100000); end
    checks++; if (bus.dst_we !== 24'h100000) begin errors++; $display("[TB] FAIL single_dst_we: got %h expected %h", bus.dst_we, 24'h100000); end
    tick();
    expXfer = expXfer + 1;
    checks++; if (bus.src_oe !== 24'h0) begin errors++; $display("[TB] FAIL single_one_cycle: src_oe got %h expected %h", bus.src_oe, 24'h0); end
    checks++; if (bus.dst_we !== 24'h0) begin errors++; $display("[TB] FAIL single_one_cycle_dst: got %h expected %h", bus.dst_we, 24'h0); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL single_busy_drop: got %b expected 0", bus.busy); end
    checks++; if (bus.xfer_count !== (StatsOn ? 16'(expXfer) : 16'd0)) begin errors++; $display("[TB] FAIL single_xfer_count: got %0d expected %0d", bus.xfer_count, StatsOn ? expXfer : 0); end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  srcTab [4] = '{5'd1, 5'd18, 5'd2, 5'd23};
    logic [4:0]  dstTab [4] = '{5'd22, 5'd2, 5'd20, 5'd0};
    logic [23:0] expSrc;
    logic [23:0] expDst;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        applyStimulus(1'b1, srcTab[i], dstTab[i], 1'b0);
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL stream_ready_%0d: got %b expected 1", i, bus.cmd_ready); end
      end else begin
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0);
      end
      tick();
      if (i > 0) begin
        expSrc = 24'h1 << srcTab[i-1];
        expDst = 24'h1 << dstTab[i-1];
        checks++; if (bus.src_oe !== expSrc) begin errors++; $display("[TB] FAIL stream_src_%0d: got %h expected %h", i-1, bus.src_oe, expSrc); end
        checks++; if (bus.dst_we !== expDst) begin errors++; $display("[TB] FAIL stream_dst_%0d: got %h expected %h", i-1, bus.dst_we, expDst); end
      end
    end
    tick();
    expXfer = expXfer + 4;
    checks++; if (bus.src_oe !== 24'h0) begin errors++; $display("[TB] FAIL stream_end_src: got %h expected %h", bus.src_oe, 24'h0); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL stream_end_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.xfer_count !== (StatsOn ? 16'(expXfer) : 16'd0)) begin errors++; $display("[TB] FAIL stream_xfer_count: got %0d expected %0d", bus.xfer_count, StatsOn ? expXfer : 0); end
  endtask

  task automatic test_memory();
    bus.mem_done = 1'b1;
    tick();
    bus.mem_done = 1'b0;
    checks++; if (bus.mem_read !== 1'b0) begin errors++; $display("[TB] FAIL stray_done_mem_read: got %b expected 0", bus.mem_read); end
    checks++; if (bus.src_oe !== 24'h0) begin errors++; $display("[TB] FAIL stray_done_src_oe: got %h expected %h", bus.src_oe, 24'h0); end
    applyStimulus(1'b1, 5'd21, 5'd23, 1'b1);
    tick();
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0);
    for (int c = 1; c <= 3; c++) begin
      tick();
      checks++; if (bus.mem_read !== 1'b1) begin errors++; $display("[TB] FAIL mem_wait_read_%0d: got %b expected 1", c, bus.mem_read); end
      checks++; if (bus.src_oe !== 24'h0) begin errors++; $display("[TB] FAIL mem_wait_src_%0d: got %h expected %h", c, bus.src_oe, 24'h0); end
    end
    bus.mem_done = 1'b1;
    tick();
    bus.mem_done = 1'b0;
    checks++; if (bus.mem_read !== 1'b0) begin errors++; $display("[TB] FAIL mem_issue_read: got %b expected 0", bus.mem_read); end
    checks++; if (bus.src_oe !== 24'h200000) begin errors++; $display("[TB] FAIL mem_issue_src: got %h expected %h", bus.src_oe, 24'h200000); end
    checks++; if (bus.dst_we !== 24'h800000) begin errors++; $display("[TB] FAIL mem_issue_dst: got %h expected %h", bus.dst_we, 24'h800000); end
    tick();
    expXfer = expXfer + 1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL mem_end_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("[TB] FAIL mem_end_err: got %b expected 0", bus.err); end
  endtask

  task automatic test_timeout_illegal();
    int  waitCycles;
    bit  sawIssue;
    bit  sawErr;
    applyStimulus(1'b1, 5'd21, 5'd19, 1'b1);
    tick();
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0);
    tick();
    waitCycles = 0;
    sawIssue   = 1'b0;
    sawErr     = 1'b0;
    for (int k = 0; k < 40 && bus.mem_read === 1'b1; k++) begin
      waitCycles++;
      if (bus.src_oe !== 24'h0) sawIssue = 1'b1;
      if (bus.err !== 1'b0) sawErr = 1'b1;
      tick();
    end
    checks++; if (waitCycles != 15) begin errors++; $display("[TB] FAIL timeout_length: got %0d expected 15", waitCycles); end
    checks++; if (sawErr || sawIssue) begin errors++; $display("[TB] FAIL timeout_quiet_wait: err/issue seen got %b%b expected 00", sawErr, sawIssue); end
    checks++; if (bus.err !== 1'b1) begin errors++; $display("[TB] FAIL timeout_err: got %b expected 1", bus.err); end
    checks++; if (bus.src_oe !== 24'h0) begin errors++; $display("[TB] FAIL timeout_dropped: src_oe got %h expected %h", bus.src_oe, 24'h0); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL timeout_busy: got %b expected 0", bus.busy); end
    tick();
    checks++; if (bus.err !== 1'b0) begin errors++; $display("[TB] FAIL timeout_err_pulse: got %b expected 0", bus.err); end
    applyStimulus(1'b1, 5'd25, 5'd3, 1'b0);
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL illegal_ready: got %b expected 1", bus.cmd_ready); end
    tick();
    applyStimulus(1'b1, 5'd3, 5'd30, 1'b0);
    checks++; if (bus.err !== 1'b1) begin errors++; $display("[TB] FAIL illegal_src_err: got %b expected 1", bus.err); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL illegal_src_not_queued: busy got %b expected 0", bus.busy); end
    tick();
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0);
    checks++; if (bus.err !== 1'b1) begin errors++; $display("[TB] FAIL illegal_dst_err: got %b expected 1", bus.err); end
    tick();
    checks++; if (bus.err !== 1'b0) begin errors++; $display("[TB] FAIL illegal_err_pulse: got %b expected 0", bus.err); end
    checks++; if (bus.src_oe !== 24'h0 || bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL illegal_no_issue: src_oe %h busy %b expected 000000 0", bus.src_oe, bus.busy); end
    checks++; if (bus.xfer_count !== (StatsOn ? 16'(expXfer) : 16'd0)) begin errors++; $display("[TB] FAIL timeout_xfer_count: got %0d expected %0d", bus.xfer_count, StatsOn ? expXfer : 0); end
  endtask

  task automatic test_full_wrap();
    logic [4:0]  srcTab [10] = '{5'd0, 5'd3, 5'd7, 5'd15, 5'd16, 5'd17, 5'd19, 5'd22, 5'd5, 5'd3};
    logic [4:0]  dstTab [10] = '{5'd1, 5'd3, 5'd8, 5'd15, 5'd16, 5'd17, 5'd18, 5'd21, 5'd23, 5'd4};
    logic [23:0] expSrc;
    logic [23:0] expDst;
    // A stalls in WAIT_MEM while the queue fills to four entries behind it.
    applyStimulus(1'b1, 5'd21, 5'd16, 1'b1);
    tick();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, srcTab[i], dstTab[i], 1'b0);
      tick();
    end
    applyStimulus(1'b1, srcTab[4], dstTab[4], 1'b0);
    checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_ready_low: got %b expected 0", bus.cmd_ready); end
    checks++; if (bus.mem_read !== 1'b1) begin errors++; $display("[TB] FAIL full_stalled: mem_read got %b expected 1", bus.mem_read); end
    bus.mem_done = 1'b1;
    tick();
    bus.mem_done = 1'b0;
    checks++; if (bus.src_oe !== 24'h200000 || bus.dst_we !== 24'h010000) begin errors++; $display("[TB] FAIL full_issue_a: src %h dst %h expected 200000 010000", bus.src_oe, bus.dst_we); end
    for (int s = 0; s < 10; s++) begin
      if (s + 4 < 10) begin
        applyStimulus(1'b1, srcTab[s+4], dstTab[s+4], 1'b0);
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL full_pushpop_ready_%0d: got %b expected 1", s, bus.cmd_ready); end
      end else begin
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0);
      end
      tick();
      expSrc = 24'h1 << srcTab[s];
      expDst = 24'h1 << dstTab[s];
      checks++; if (bus.src_oe !== expSrc || bus.dst_we !== expDst) begin errors++; $display("[TB] FAIL full_order_%0d: src %h dst %h expected %h %h", s, bus.src_oe, bus.dst_we, expSrc, expDst); end
    end
    tick();
    expXfer = expXfer + 11;
    checks++; if (bus.busy !== 1'b0 || bus.src_oe !== 24'h0) begin errors++; $display("[TB] FAIL full_drained: busy %b src %h expected 0 000000", bus.busy, bus.src_oe); end
    checks++; if (bus.xfer_count !== (StatsOn ? 16'(expXfer) : 16'd0)) begin errors++; $display("[TB] FAIL full_xfer_count: got %0d expected %0d", bus.xfer_count, StatsOn ? expXfer : 0); end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    expXfer      = 0;
    clear        = 1'b0;
    bus.mem_done = 1'b0;
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0);
    $display("[TB] starting bus_transfer_sequencer bench");
    test_reset();
    test_single();
    test_back_to_back();
    test_memory();
    test_timeout_illegal();
    test_full_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
